// File: rtl/fowarding_pkg.sv
// Shared types and helpers for the forwarding / hazard scoreboard.
// Holds the select-width helper, the register-file select code and the default register address type.
package fowarding_pkg;

    localparam int REG_W_DEF = 5;
    localparam int FWD_RF    = 0;

    typedef logic [REG_W_DEF-1:0] reg_addr_t;

    // Select width needed to encode "register file" plus one code per forwarding stage
    function automatic int sel_width(input int num_fwd);
        return $clog2(num_fwd + 1);
    endfunction

endpackage

// File: rtl/fwd_prio_sel.sv
// Priority encoder choosing the forwarding source for one EX operand port.
// Stage 0 is the youngest result and wins over older stages; register 0 never forwards.
module fwd_prio_sel
    import fowarding_pkg::*;
#(
    parameter int REG_W   = 5,
    parameter int NUM_FWD = 2,
    parameter int SEL_W   = sel_width(NUM_FWD)
) (
    input  logic [REG_W-1:0]         rs,
    input  logic [NUM_FWD*REG_W-1:0] fwd_rd,
    input  logic [NUM_FWD-1:0]       fwd_we,
    output logic [SEL_W-1:0]         sel
);

    logic [SEL_W-1:0]   sel_s;
    logic [NUM_FWD-1:0] hit_s;

    // Walk from oldest to youngest so the lowest matching stage ends up selected
    always_comb begin
        sel_s = SEL_W'(FWD_RF);
        hit_s = {NUM_FWD{1'b0}};
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            hit_s[k] = fwd_we[k] && (fwd_rd[k*REG_W +: REG_W] != {REG_W{1'b0}})
                       && (fwd_rd[k*REG_W +: REG_W] == rs);
            sel_s    = hit_s[k] ? SEL_W'(k + 1) : sel_s;
        end
    end

    assign sel = sel_s;

endmodule

// File: rtl/fowarding_scoreboard.sv
// Forwarding and hazard unit: per-operand forward selects plus a per-register latency scoreboard.
// Optional FWD_STATS_EN adds free-running stall-cycle and forward-hit counters.
module fowarding_scoreboard
    import fowarding_pkg::*;
#(
    parameter int REG_W   = 5,
    parameter int NUM_SRC = 2,
    parameter int NUM_FWD = 2,
    parameter int LAT_W   = 3,
    parameter int SEL_W   = sel_width(NUM_FWD)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_SRC*REG_W-1:0] rs_ex,
    input  logic [NUM_SRC*REG_W-1:0] rs_id,
    input  logic [NUM_SRC-1:0]       rs_id_used,
    input  logic [NUM_FWD*REG_W-1:0] fwd_rd,
    input  logic [NUM_FWD-1:0]       fwd_we,
    input  logic                     issue_valid,
    input  logic [REG_W-1:0]         issue_rd,
    input  logic [LAT_W-1:0]         issue_lat,
    input  logic                     flush,
    output logic [NUM_SRC*SEL_W-1:0] forward_sel,
    output logic                     stall,
    output logic [(2**REG_W)-1:0]    pending
`ifdef FWD_STATS_EN
    ,
    output logic [31:0]              stall_cycles,
    output logic [31:0]              fwd_hits
`endif
);

    localparam int NUM_REGS = 2**REG_W;

    logic [LAT_W-1:0] cnt_r     [NUM_REGS];
    logic [LAT_W-1:0] cnt_nxt_s [NUM_REGS];
    logic [LAT_W-1:0] dec_s     [NUM_REGS];
    logic             issue_ok_s;
    logic             stall_s;

    genvar p;
    generate
        for (p = 0; p < NUM_SRC; p++) begin : g_port
            fwd_prio_sel #(
                .REG_W   (REG_W),
                .NUM_FWD (NUM_FWD),
                .SEL_W   (SEL_W)
            ) u_sel (
                .rs     (rs_ex[p*REG_W +: REG_W]),
                .fwd_rd (fwd_rd),
                .fwd_we (fwd_we),
                .sel    (forward_sel[p*SEL_W +: SEL_W])
            );
        end
    endgenerate

    // Decode stall looks only at registered scoreboard state, never at this cycle's issue
    always_comb begin
        stall_s = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            stall_s = stall_s | (rs_id_used[i]
                                 && (rs_id[i*REG_W +: REG_W] != {REG_W{1'b0}})
                                 && pending[rs_id[i*REG_W +: REG_W]]);
        end
    end

    assign stall      = stall_s;
    assign issue_ok_s = issue_valid && !stall_s && !flush
                        && (issue_rd != {REG_W{1'b0}}) && (issue_lat != {LAT_W{1'b0}});

    // Next counter values: saturating decrement, and on issue keep the longer of old and new wait
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            dec_s[r] = (cnt_r[r] != {LAT_W{1'b0}}) ? (cnt_r[r] - LAT_W'(1)) : {LAT_W{1'b0}};
            if (r == 0) begin
                cnt_nxt_s[r] = {LAT_W{1'b0}};
            end else if (issue_ok_s && (issue_rd == REG_W'(r))) begin
                cnt_nxt_s[r] = (dec_s[r] > issue_lat) ? dec_s[r] : issue_lat;
            end else begin
                cnt_nxt_s[r] = dec_s[r];
            end
        end
    end

    // Scoreboard state; reset and flush both discard every in-flight entry
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_r[r] <= {LAT_W{1'b0}};
            end
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_pend
            assign pending[g] = (cnt_r[g] != {LAT_W{1'b0}});
        end
    endgenerate

`ifdef FWD_STATS_EN
    logic [31:0] stall_cycles_r;
    logic [31:0] fwd_hits_r;

    // Statistics survive flush; only reset clears them
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_r <= 32'd0;
            fwd_hits_r     <= 32'd0;
        end else begin
            stall_cycles_r <= stall_s ? (stall_cycles_r + 32'd1) : stall_cycles_r;
            fwd_hits_r     <= (forward_sel != {(NUM_SRC*SEL_W){1'b0}}) ? (fwd_hits_r + 32'd1) : fwd_hits_r;
        end
    end

    assign stall_cycles = stall_cycles_r;
    assign fwd_hits     = fwd_hits_r;
`endif

endmodule

// File: tb/tb_fowarding_scoreboard.sv
// Directed self-checking bench for fowarding_scoreboard (default parameters).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_fowarding_scoreboard;

    logic        clk;
    logic        reset;
    logic [9:0]  rs_ex;
    logic [9:0]  rs_id;
    logic [1:0]  rs_id_used;
    logic [9:0]  fwd_rd;
    logic [1:0]  fwd_we;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [2:0]  issue_lat;
    logic        flush;
    logic [3:0]  forward_sel;
    logic        stall;
    logic [31:0] pending;
`ifdef FWD_STATS_EN
    logic [31:0] stall_cycles;
    logic [31:0] fwd_hits;
`endif

    int pass_cnt  = 0;
    int check_cnt = 0;

    fowarding_scoreboard dut (
        .clk         (clk),
        .reset       (reset),
        .rs_ex       (rs_ex),
        .rs_id       (rs_id),
        .rs_id_used  (rs_id_used),
        .fwd_rd      (fwd_rd),
        .fwd_we      (fwd_we),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_lat   (issue_lat),
        .flush       (flush),
        .forward_sel (forward_sel),
        .stall       (stall),
        .pending     (pending)
`ifdef FWD_STATS_EN
        ,
        .stall_cycles(stall_cycles),
        .fwd_hits    (fwd_hits)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        rs_ex = 10'd0; rs_id = 10'd0; rs_id_used = 2'b00;
        fwd_rd = 10'd0; fwd_we = 2'b00;
        issue_valid = 1'b0; issue_rd = 5'd0; issue_lat = 3'd0; flush = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drain();
        idle();
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        check_cnt++; if (pending !== 32'd0) $display("FAIL reset_pending: got %h want 0", pending); else pass_cnt++;
        check_cnt++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall); else pass_cnt++;
        check_cnt++; if (forward_sel !== 4'd0) $display("FAIL reset_fsel: got %h want 0", forward_sel); else pass_cnt++;
    endtask

    task automatic test_forward();
        @(negedge clk); idle();
        fwd_rd = {5'd5, 5'd5}; fwd_we = 2'b11; rs_ex = {5'd0, 5'd5}; #1;
        check_cnt++; if (forward_sel[1:0] !== 2'd1) $display("FAIL fwd_both: got %0d want 1", forward_sel[1:0]); else pass_cnt++;
        fwd_we = 2'b10; #1;
        check_cnt++; if (forward_sel[1:0] !== 2'd2) $display("FAIL fwd_old: got %0d want 2", forward_sel[1:0]); else pass_cnt++;
        fwd_rd = {5'd0, 5'd0}; fwd_we = 2'b11; rs_ex = 10'd0; #1;
        check_cnt++; if (forward_sel !== 4'd0) $display("FAIL fwd_r0: got %h want 0", forward_sel); else pass_cnt++;
        fwd_rd = {5'd5, 5'd6}; fwd_we = 2'b11; rs_ex = {5'd5, 5'd6}; #1;
        check_cnt++; if (forward_sel !== 4'b1001) $display("FAIL fwd_ports: got %b want 1001", forward_sel); else pass_cnt++;
        rs_ex = {5'd7, 5'd7}; #1;
        check_cnt++; if (forward_sel !== 4'd0) $display("FAIL fwd_nomatch: got %h want 0", forward_sel); else pass_cnt++;
        idle();
    endtask

    task automatic test_load_use();
        @(negedge clk); idle();
        issue_valid = 1'b1; issue_rd = 5'd7; issue_lat = 3'd2;
        rs_id = {5'd0, 5'd7}; rs_id_used = 2'b01; #1;
        check_cnt++; if (stall !== 1'b0) $display("FAIL lu_same_cycle: got %b want 0", stall); else pass_cnt++;
        @(negedge clk); issue_valid = 1'b0; #1;
        check_cnt++; if (stall !== 1'b1) $display("FAIL lu_T: got %b want 1", stall); else pass_cnt++;
        check_cnt++; if (pending[7] !== 1'b1) $display("FAIL lu_pend_T: got %b want 1", pending[7]); else pass_cnt++;
        @(negedge clk); #1;
        check_cnt++; if (stall !== 1'b1) $display("FAIL lu_T1: got %b want 1", stall); else pass_cnt++;
        @(negedge clk); #1;
        check_cnt++; if (stall !== 1'b0) $display("FAIL lu_T2: got %b want 0", stall); else pass_cnt++;
        check_cnt++; if (pending[7] !== 1'b0) $display("FAIL lu_pend_T2: got %b want 0", pending[7]); else pass_cnt++;
        idle();
    endtask

    task automatic test_waw();
        @(negedge clk); idle();
        issue_valid = 1'b1; issue_rd = 5'd9; issue_lat = 3'd3;
        @(negedge clk); issue_lat = 3'd1; #1;
        check_cnt++; if (pending[9] !== 1'b1) $display("FAIL waw_load: got %b want 1", pending[9]); else pass_cnt++;
        @(negedge clk); issue_valid = 1'b0; #1;
        check_cnt++; if (pending[9] !== 1'b1) $display("FAIL waw_c2: got %b want 1", pending[9]); else pass_cnt++;
        @(negedge clk); #1;
        check_cnt++; if (pending[9] !== 1'b1) $display("FAIL waw_c1: got %b want 1", pending[9]); else pass_cnt++;
        @(negedge clk); #1;
        check_cnt++; if (pending[9] !== 1'b0) $display("FAIL waw_c0: got %b want 0", pending[9]); else pass_cnt++;
        issue_valid = 1'b1; issue_lat = 3'd3;
        @(negedge clk); issue_lat = 3'd6;
        @(negedge clk); issue_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            check_cnt++; if (pending[9] !== 1'b1) $display("FAIL waw_long_%0d: got %b want 1", i, pending[9]); else pass_cnt++;
            @(negedge clk);
        end
        #1;
        check_cnt++; if (pending[9] !== 1'b0) $display("FAIL waw_long_end: got %b want 0", pending[9]); else pass_cnt++;
        idle();
    endtask

    task automatic test_issue_while_stalled();
        @(negedge clk); idle();
        issue_valid = 1'b1; issue_rd = 5'd7; issue_lat = 3'd3;
        rs_id = {5'd4, 5'd7}; rs_id_used = 2'b01;
        @(negedge clk); issue_rd = 5'd4; issue_lat = 3'd5; #1;
        check_cnt++; if (stall !== 1'b1) $display("FAIL iws_stall: got %b want 1", stall); else pass_cnt++;
        @(negedge clk); issue_valid = 1'b0; #1;
        check_cnt++; if (pending[4] !== 1'b0) $display("FAIL iws_rejected: got %b want 0", pending[4]); else pass_cnt++;
        check_cnt++; if (stall !== 1'b1) $display("FAIL iws_still: got %b want 1", stall); else pass_cnt++;
        rs_id_used = 2'b00; #1;
        check_cnt++; if (stall !== 1'b0) $display("FAIL iws_unused: got %b want 0", stall); else pass_cnt++;
        check_cnt++; if (pending[7] !== 1'b1) $display("FAIL iws_pend7: got %b want 1", pending[7]); else pass_cnt++;
        drain();
    endtask

    task automatic test_flush_reset();
        @(negedge clk); idle();
        issue_valid = 1'b1; issue_rd = 5'd3; issue_lat = 3'd5;
        @(negedge clk); issue_valid = 1'b0; #1;
        check_cnt++; if (pending[3] !== 1'b1) $display("FAIL fl_pre: got %b want 1", pending[3]); else pass_cnt++;
        flush = 1'b1; issue_valid = 1'b1; issue_rd = 5'd8; issue_lat = 3'd4;
        @(negedge clk); idle(); rs_id = {5'd8, 5'd3}; rs_id_used = 2'b11; #1;
        check_cnt++; if (pending !== 32'd0) $display("FAIL fl_pending: got %h want 0", pending); else pass_cnt++;
        check_cnt++; if (stall !== 1'b0) $display("FAIL fl_stall: got %b want 0", stall); else pass_cnt++;
        issue_valid = 1'b1; issue_rd = 5'd3; issue_lat = 3'd5; rs_id_used = 2'b00;
        @(negedge clk); issue_valid = 1'b0; rs_id_used = 2'b01; #1;
        check_cnt++; if (stall !== 1'b1) $display("FAIL rst_pre: got %b want 1", stall); else pass_cnt++;
        reset = 1'b1;
        @(negedge clk); reset = 1'b0; #1;
        check_cnt++; if (pending !== 32'd0) $display("FAIL rst_pending: got %h want 0", pending); else pass_cnt++;
        check_cnt++; if (stall !== 1'b0) $display("FAIL rst_stall: got %b want 0", stall); else pass_cnt++;
        idle();
    endtask

`ifdef FWD_STATS_EN
    task automatic test_stats();
        do_reset();
        issue_valid = 1'b1; issue_rd = 5'd7; issue_lat = 3'd3;
        @(negedge clk); issue_valid = 1'b0; rs_id = {5'd0, 5'd7}; rs_id_used = 2'b01;
        repeat (4) @(negedge clk);
        rs_id_used = 2'b00; fwd_rd = {5'd0, 5'd2}; fwd_we = 2'b01; rs_ex = {5'd0, 5'd2};
        repeat (2) @(negedge clk);
        idle(); #1;
        check_cnt++; if (stall_cycles !== 32'd3) $display("FAIL st_stall: got %0d want 3", stall_cycles); else pass_cnt++;
        check_cnt++; if (fwd_hits !== 32'd2) $display("FAIL st_hits: got %0d want 2", fwd_hits); else pass_cnt++;
        flush = 1'b1;
        @(negedge clk); flush = 1'b0; #1;
        check_cnt++; if (stall_cycles !== 32'd3) $display("FAIL st_flush_stall: got %0d want 3", stall_cycles); else pass_cnt++;
        check_cnt++; if (fwd_hits !== 32'd2) $display("FAIL st_flush_hits: got %0d want 2", fwd_hits); else pass_cnt++;
        do_reset(); #1;
        check_cnt++; if (stall_cycles !== 32'd0) $display("FAIL st_rst_stall: got %0d want 0", stall_cycles); else pass_cnt++;
        check_cnt++; if (fwd_hits !== 32'd0) $display("FAIL st_rst_hits: got %0d want 0", fwd_hits); else pass_cnt++;
    endtask
`endif

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_forward();
        test_load_use();
        test_waw();
        test_issue_while_stalled();
        test_flush_reset();
`ifdef FWD_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/fowarding_scoreboard.md
Name: fowarding_scoreboard

Overview:
- Parametrised forwarding and hazard unit for the pipelined core.
- Generates per-operand forward selects from any number of in-flight write stages.
- Tracks pending long-latency writes (loads, multi-cycle ALU ops) in a per-register countdown scoreboard and raises a decode-stage stall on use.
- Sits between ID/EX pipeline registers and the EX operand muxes; drives the ID/IF stall line.

Parameters:
- REG_W, 5, register address width (2**REG_W architectural registers; register 0 hard-wired zero).
- NUM_SRC, 2, operand read ports per instruction.
- NUM_FWD, 2, forwarding source stages; index 0 = youngest (MEM), highest priority.
- LAT_W, 3, width of the pending-latency counter (max latency 2**LAT_W-1 cycles).

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- rs_ex  input  NUM_SRC*REG_W  EX-stage source register addresses, port p at [p*REG_W +: REG_W].
- rs_id  input  NUM_SRC*REG_W  ID-stage source register addresses, same packing.
- rs_id_used  input  NUM_SRC  per-port "operand actually read" qualifier.
- fwd_rd  input  NUM_FWD*REG_W  destination register of each forwarding stage.
- fwd_we  input  NUM_FWD  RegWrite of each forwarding stage.
- issue_valid  input  1  long-latency op leaving ID this cycle.
- issue_rd  input  REG_W  its destination.
- issue_lat  input  LAT_W  cycles until its result is forwardable.
- flush  input  1  pipeline flush; clears the scoreboard.
- forward_sel  output  NUM_SRC*SEL_W  per-port select; 0 = register file, k = stage k-1.
- stall  output  1  hold PC and IF/ID, bubble ID/EX.
- pending  output  2**REG_W  per-register busy vector (debug/trace).

Behaviour:
- SEL_W = clog2(NUM_FWD+1).
- Forward select, combinational: for each port p, the lowest stage k with fwd_we[k], fwd_rd[k] != 0 and fwd_rd[k] == rs_ex[p] gives sel = k+1; no match gives 0. Address 0 always selects 0.
- Scoreboard: one LAT_W-bit counter per register, cnt[0] constant 0; pending[r] = (cnt[r] != 0).
- Each cycle every nonzero counter decrements by 1, saturating at 0.
- Issue is accepted only when issue_valid && !stall && !flush && issue_rd != 0 && issue_lat != 0. Accepted issue loads cnt[issue_rd] = max(cnt[issue_rd]-1, issue_lat) on that edge. The new value is not decremented in the same cycle; WAW keeps the longer wait.
- Issue with issue_lat = 0 creates no entry. The normal forwarding path covers it.
- stall = OR over p of (rs_id_used[p] && rs_id[p] != 0 && pending[rs_id[p]]). Combinational from registered state only. Independent of the same-cycle issue.
- Latency semantics: an op issued at edge T with lat L stalls a dependent in ID for cycles T..T+L-1. At cycle T+L the dependent proceeds and the result is expected on a forwarding stage.
- flush: all counters are 0 after the edge. flush beats a simultaneous issue.
- Reset: all counters 0, pending = 0, stall = 0, forward_sel combinational (0 when no fwd_we). Reset mid-countdown discards all entries.

Optional Feature:
- FWD_STATS_EN defined: adds output stall_cycles (32 bits) and fwd_hits (32 bits).
  - stall_cycles increments each cycle stall = 1.
  - fwd_hits increments each cycle any forward_sel port is nonzero.
  - Both wrap at 2**32, clear on reset, and do not clear on flush.
- Not defined: ports and counters absent; no other behavioural change.

Decomposition:
- Package fowarding_pkg holds:
  - the SEL_W helper function;
  - constant FWD_RF = 0;
  - typedef reg_addr_t (REG_W bits, default 5).
- One sub-module, fwd_prio_sel: the priority encoder for one operand port, instantiated NUM_SRC times by generate.
- The scoreboard stays in the top module.

Test Plan:
- Forward priority: fwd_rd = {5,5}, fwd_we = 11, rs_ex port0 = 5 -> sel0 = 1. With fwd_we = 10 -> sel0 = 2. With rs_ex = 0 and both stages writing r0 -> sel0 = 0.
- Load-use: issue rd = 7, lat = 2 at edge T; rs_id = 7, used = 1 -> stall high cycles T and T+1, low at T+2; pending[7] mirrors this.
- WAW max: cnt[9] = 3, issue rd = 9 lat = 1 -> cnt[9] = 2 next cycle. Issue lat = 6 -> cnt[9] = 6.
- Issue while stalled: stall = 1, issue_valid = 1 rd = 4 -> cnt[4] unchanged. Unused port (rs_id_used = 0) on a pending register -> no stall.
- Flush vs issue same edge: cnt[3] = 5, flush = 1, issue rd = 8 lat = 4 -> all counters 0, stall = 0 next cycle. Reset asserted mid-countdown -> same result.
- FWD_STATS_EN build: 3 stall cycles plus 2 forward cycles -> stall_cycles = 3, fwd_hits = 2. Values survive flush, zero after reset.
